// File: rtl/neuron_mac_unit.sv
// neuron_mac_unit
//   Sequential multiply-accumulate for one neuron. After a start the unit
//   takes N_INPUTS signed (x_in, w_in) pairs, one per accepted beat, and
//   sums their full-precision products onto the sampled bias. The final sum
//   is presented on acc_out with ready_signal for the activation stage.
//
// Ports
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   start, bias      begin evaluation (sampled in IDLE/DONE), bias loaded then
//   in_valid/in_ready, x_in, w_in   operand pair handshake (ready only in ACCUM)
//   acc_out          accumulator register (meaningful while ready_signal=1)
//   ready_signal     evaluation finished, acc_out stable (DONE state)
//   busy             evaluation in progress (ACCUM state)
//   sat_flag         sticky clamp indicator for the current evaluation
//
// Configuration
//   NEURON_MAC_SAT_EN  defined: each add clamps to the signed WIDTH range and
//                      sets a sticky saturation flag.
//                      undefined: adds wrap modulo 2**WIDTH, sat_flag = 0.
module neuron_mac_unit #(
  parameter int WIDTH    = 32,
  parameter int DATA_W   = 8,
  parameter int N_INPUTS = 62,
  parameter int CNT_W    = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic signed [WIDTH-1:0]  bias,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] x_in,
  input  logic signed [DATA_W-1:0] w_in,
  output logic signed [WIDTH-1:0]  acc_out,
  output logic                     ready_signal,
  output logic                     busy,
  output logic                     sat_flag
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_INPUTS - 1);

  state_e                    state_q;
  logic signed [WIDTH-1:0]   acc_q;
  logic        [CNT_W-1:0]   cnt_q;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [WIDTH-1:0]   acc_d;

  // Full 2*DATA_W product, so (-128)*(-128) is exact.
  assign prod = x_in * w_in;

`ifdef NEURON_MAC_SAT_EN
  logic                    sat_q;
  logic signed [WIDTH:0]   sum_x;
  logic                    clamp;

  // One guard bit: the top two bits disagree exactly when the add overflowed.
  assign sum_x = {acc_q[WIDTH-1], acc_q}
               + {{(WIDTH+1-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  assign clamp = sum_x[WIDTH] ^ sum_x[WIDTH-1];

  always_comb begin
    acc_d = sum_x[WIDTH-1:0];
    if (clamp)
      acc_d = sum_x[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                           : {1'b0, {(WIDTH-1){1'b1}}};
  end

  assign sat_flag = sat_q;
`else
  assign acc_d    = acc_q + {{(WIDTH-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  assign sat_flag = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
`ifdef NEURON_MAC_SAT_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            acc_q   <= bias;
            cnt_q   <= '0;
`ifdef NEURON_MAC_SAT_EN
            sat_q   <= 1'b0;
`endif
            state_q <= ACCUM;
          end
        end
        ACCUM: begin
          // in_ready is the ACCUM decode, so in_valid alone marks a beat.
          if (in_valid) begin
            acc_q <= acc_d;
`ifdef NEURON_MAC_SAT_EN
            if (clamp) sat_q <= 1'b1;
`endif
            // Counter parks at LAST rather than wrapping.
            if (cnt_q == LAST) state_q <= DONE;
            else               cnt_q   <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy         = (state_q == ACCUM);
  assign in_ready     = (state_q == ACCUM);
  assign ready_signal = (state_q == DONE);
  assign acc_out      = acc_q;

endmodule

// File: tb/tb_neuron_mac_unit.sv
module tb_neuron_mac_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main DUT: WIDTH=32, N_INPUTS=4
  logic               start = 0, in_valid = 0;
  logic signed [31:0] bias = 0;
  logic signed [7:0]  x_in = 0, w_in = 0;
  logic               in_ready, ready_signal, busy, sat_flag;
  logic signed [31:0] acc_out;

  neuron_mac_unit #(.WIDTH(32), .DATA_W(8), .N_INPUTS(4), .CNT_W(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bias(bias), .in_valid(in_valid),
    .in_ready(in_ready), .x_in(x_in), .w_in(w_in), .acc_out(acc_out),
    .ready_signal(ready_signal), .busy(busy), .sat_flag(sat_flag));

  // Narrow DUT: WIDTH=17, N_INPUTS=1
  logic               start17 = 0, in_valid17 = 0;
  logic signed [16:0] bias17 = 0;
  logic signed [7:0]  x17 = 0, w17 = 0;
  logic               in_ready17, ready17, busy17, sat17;
  logic signed [16:0] acc17;

  neuron_mac_unit #(.WIDTH(17), .DATA_W(8), .N_INPUTS(1), .CNT_W(1)) u_dut17 (
    .clk(clk), .rst_n(rst_n), .start(start17), .bias(bias17), .in_valid(in_valid17),
    .in_ready(in_ready17), .x_in(x17), .w_in(w17), .acc_out(acc17),
    .ready_signal(ready17), .busy(busy17), .sat_flag(sat17));

  int errors = 0;
  int checks = 0;

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Reference: plain integer accumulation, then clamp or wrap into WIDTH bits
  // after every add.
  task automatic ref_model(input int width, input longint b, input int xs[$],
                           input int ws[$], output longint res, output bit sat);
    longint maxv, minv, span;
    span = longint'(1) <<< width;
    maxv = (longint'(1) <<< (width - 1)) - 1;
    minv = -(longint'(1) <<< (width - 1));
    res = b;
    sat = 0;
    foreach (xs[i]) begin
      res = res + longint'(xs[i]) * longint'(ws[i]);
`ifdef NEURON_MAC_SAT_EN
      if (res > maxv) begin res = maxv; sat = 1; end
      if (res < minv) begin res = minv; sat = 1; end
`else
      res = res & (span - 1);
      if (res > maxv) res = res - span;
`endif
    end
  endtask

  // One full evaluation on the main DUT. gap: max idle cycles before each beat.
  // noise: also assert start during ACCUM (must be ignored).
  task automatic run_eval(input string nm, input longint b, input int xs[$],
                          input int ws[$], input int gap, input bit noise);
    longint exp_acc;
    bit     exp_sat;
    int     g;
    ref_model(32, b, xs, ws, exp_acc, exp_sat);
    start = 1; bias = 32'(b);
    step();
    start = 0;
    checks++;
    if (ready_signal !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_enter ready=%b busy=%b in_ready=%b want 0/1/1", nm, ready_signal, busy, in_ready);
    end
    foreach (xs[i]) begin
      g = (gap > 0) ? $urandom_range(gap, 0) : 0;
      repeat (g) begin
        in_valid = 0;
        if (noise) begin start = 1; bias = $urandom; end
        step();
        checks++;
        if (in_ready !== 1'b1 || ready_signal !== 1'b0) begin
          errors++;
          $display("FAIL %s_gap in_ready=%b ready=%b want 1/0", nm, in_ready, ready_signal);
        end
      end
      in_valid = 1; x_in = 8'(xs[i]); w_in = 8'(ws[i]);
      if (noise) begin start = 1; bias = $urandom; end
      step();
      in_valid = 0; start = 0;
      if (i != xs.size() - 1) begin
        checks++;
        if (ready_signal !== 1'b0) begin
          errors++;
          $display("FAIL %s_early ready=%b after beat %0d want 0", nm, ready_signal, i);
        end
      end
    end
    checks++;
    if (ready_signal !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_done ready=%b busy=%b in_ready=%b want 1/0/0", nm, ready_signal, busy, in_ready);
    end
    checks++;
    if (longint'(acc_out) !== exp_acc) begin
      errors++;
      $display("FAIL %s_acc got=%0d want=%0d", nm, acc_out, exp_acc);
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    #12;
    checks++;
    if (acc_out !== 0 || ready_signal !== 0 || busy !== 0 || in_ready !== 0 || sat_flag !== 0
        || acc17 !== 0 || ready17 !== 0 || busy17 !== 0 || sat17 !== 0) begin
      errors++;
      $display("FAIL reset_hold acc=%0d rdy=%b busy=%b want all 0", acc_out, ready_signal, busy);
    end
    @(negedge clk); rst_n = 1;
    step();
    checks++;
    if (acc_out !== 0 || ready_signal !== 0 || busy !== 0 || in_ready !== 0) begin
      errors++;
      $display("FAIL reset_release acc=%0d rdy=%b busy=%b want all 0", acc_out, ready_signal, busy);
    end
  endtask

  task automatic test_back_to_back();
    run_eval("b2b", 10, '{1, 3, -5, 7}, '{2, 4, 6, -1}, 0, 0);
    checks++;
    if (acc_out !== -32'sd13) begin
      errors++;
      $display("FAIL b2b_const got=%0d want=-13", acc_out);
    end
  endtask

  task automatic test_gaps();
    run_eval("gaps", 10, '{1, 3, -5, 7}, '{2, 4, 6, -1}, 3, 0);
  endtask

  task automatic test_extremes();
    run_eval("ext", 0, '{-128, -128, -128, -128}, '{-128, -128, -128, -128}, 0, 0);
    checks++;
    if (acc_out !== 32'sd65536) begin
      errors++;
      $display("FAIL ext_const got=%0d want=65536", acc_out);
    end
    run_eval("restart", 5, '{0, 0, 0, 0}, '{0, 0, 0, 0}, 0, 0);
  endtask

  task automatic test_reset_mid();
    start = 1; bias = 100;
    step();
    start = 0;
    repeat (2) begin in_valid = 1; x_in = 8'sd9; w_in = 8'sd9; step(); end
    in_valid = 0;
    rst_n = 0;
    #2;
    checks++;
    if (acc_out !== 0 || busy !== 0 || in_ready !== 0 || ready_signal !== 0) begin
      errors++;
      $display("FAIL rstmid_async acc=%0d busy=%b in_ready=%b want 0", acc_out, busy, in_ready);
    end
    rst_n = 1;
    step();
    checks++;
    if (busy !== 0 || acc_out !== 0) begin
      errors++;
      $display("FAIL rstmid_idle busy=%b acc=%0d want 0/0", busy, acc_out);
    end
    run_eval("post_rst", 1, '{1, 1, 1, 1}, '{1, 1, 1, 1}, 0, 0);
  endtask

  task automatic test_ignore();
    logic signed [31:0] held;
    run_eval("noise", -7, '{12, -3, 100, -128}, '{5, 77, -2, 127}, 2, 1);
    held = acc_out;
    repeat (3) begin
      in_valid = 1; x_in = $urandom; w_in = $urandom;
      step();
      checks++;
      if (acc_out !== held || ready_signal !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL done_hold acc=%0d want=%0d ready=%b", acc_out, held, ready_signal);
      end
    end
    in_valid = 0;
  endtask

  task automatic test_random();
    int xs[$], ws[$];
    longint b;
    for (int n = 0; n < 6; n++) begin
      xs.delete(); ws.delete();
      for (int k = 0; k < 4; k++) begin
        xs.push_back($signed(8'($urandom)));
        ws.push_back($signed(8'($urandom)));
      end
      b = (n < 3) ? longint'($signed(32'($urandom))) : longint'($signed(12'($urandom)));
      run_eval("rand", b, xs, ws, 2, 0);
    end
  endtask

  task automatic test_narrow_sat();
    longint exp_acc;
    bit     exp_sat;
    ref_model(17, 65535, '{127}, '{127}, exp_acc, exp_sat);
    start17 = 1; bias17 = 17'sd65535;
    step();
    start17 = 0;
    in_valid17 = 1; x17 = 8'sd127; w17 = 8'sd127;
    step();
    in_valid17 = 0;
    checks++;
    if (ready17 !== 1'b1 || longint'(acc17) !== exp_acc) begin
      errors++;
      $display("FAIL w17_acc ready=%b got=%0d want=%0d", ready17, acc17, exp_acc);
    end
    checks++;
    if (sat17 !== exp_sat) begin
      errors++;
      $display("FAIL w17_sat got=%b want=%b", sat17, exp_sat);
    end
    // Flag must clear on the next start.
    start17 = 1; bias17 = 17'sd3;
    step();
    start17 = 0;
    in_valid17 = 1; x17 = -8'sd2; w17 = 8'sd5;
    step();
    in_valid17 = 0;
    checks++;
    if (ready17 !== 1'b1 || acc17 !== -17'sd7 || sat17 !== 1'b0) begin
      errors++;
      $display("FAIL w17_second ready=%b acc=%0d sat=%b want 1/-7/0", ready17, acc17, sat17);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gaps();
    test_extremes();
    test_reset_mid();
    test_ignore();
    test_random();
    test_narrow_sat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
